// File: rtl/decode_cycle.sv
// ID stage: instruction decode, 32x32 register file and the ID/EX pipeline register.
// Optional macro REGFILE_BYPASS_EN makes the read ports write-first against the writeback port.
module decode_cycle #(
   parameter bit FLUSH_CLEARS_DATA = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCD,
   input  logic [31:0] PCPlus4D,
   input  logic        RegWriteW,
   input  logic [4:0]  RDW,
   input  logic [31:0] ResultW,
   input  logic        FlushE,
   output logic        RegWriteE,
   output logic        ALUSrcE,
   output logic        MemWriteE,
   output logic        ResultSrcE,
   output logic        BranchE,
   output logic [2:0]  ALUControlE,
   output logic [31:0] RD1_E,
   output logic [31:0] RD2_E,
   output logic [31:0] Imm_Ext_E,
   output logic [4:0]  RD_E,
   output logic [4:0]  RS1_E,
   output logic [4:0]  RS2_E,
   output logic [31:0] PCE,
   output logic [31:0] PCPlus4E
);

   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,
      IMM_I    = 2'd1,
      IMM_S    = 2'd2,
      IMM_B    = 2'd3
   } imm_type_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [4:0] rd;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign rs1    = InstrD[19:15];
   assign rs2    = InstrD[24:20];
   assign rd     = InstrD[11:7];

   logic        reg_write;
   logic        alu_src;
   logic        mem_write;
   logic        result_src;
   logic        branch;
   logic [1:0]  alu_op;
   logic        is_rtype;
   imm_type_t   imm_type;
   logic [2:0]  alu_control;
   logic [31:0] imm_ext;
   logic [31:0] rd1;
   logic [31:0] rd2;

   // Main decoder; unknown opcodes fall through to the all-zero bubble.
   always_comb begin
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_write  = 1'b0;
      result_src = 1'b0;
      branch     = 1'b0;
      alu_op     = 2'b00;
      is_rtype   = 1'b0;
      imm_type   = IMM_NONE;
      unique case (opcode)
         OP_LOAD: begin
            reg_write  = 1'b1;
            alu_src    = 1'b1;
            result_src = 1'b1;
            imm_type   = IMM_I;
         end
         OP_STORE: begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
            imm_type  = IMM_S;
         end
         OP_RTYPE: begin
            reg_write = 1'b1;
            alu_op    = 2'b10;
            is_rtype  = 1'b1;
         end
         OP_IALU: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_op    = 2'b10;
            imm_type  = IMM_I;
         end
         OP_BRANCH: begin
            branch   = 1'b1;
            alu_op   = 2'b01;
            imm_type = IMM_B;
         end
         default: begin
         end
      endcase
   end

   // addi with bit 30 set must stay an add, so sub needs the R-type qualifier.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         2'b01: alu_control = ALU_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  alu_control = (is_rtype && InstrD[30]) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

   always_comb begin
      imm_ext = 32'd0;
      case (imm_type)
         IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                             InstrD[30:25], InstrD[11:8], 1'b0};
         default: imm_ext = 32'd0;
      endcase
   end

   logic [31:0] regs [32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (RegWriteW && (RDW != 5'd0)) begin
         regs[RDW] <= ResultW;
      end
   end

   // Without the bypass, a same-cycle writeback is invisible until the next read.
   always_comb begin
      rd1 = 32'd0;
      rd2 = 32'd0;
      if (rs1 != 5'd0) begin
         rd1 = regs[rs1];
`ifdef REGFILE_BYPASS_EN
         if (RegWriteW && (RDW == rs1)) begin
            rd1 = ResultW;
         end
`endif
      end
      if (rs2 != 5'd0) begin
         rd2 = regs[rs2];
`ifdef REGFILE_BYPASS_EN
         if (RegWriteW && (RDW == rs2)) begin
            rd2 = ResultW;
         end
`endif
      end
   end

   logic clear_data;
   assign clear_data = FlushE && FLUSH_CLEARS_DATA;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         MemWriteE   <= 1'b0;
         ResultSrcE  <= 1'b0;
         BranchE     <= 1'b0;
         ALUControlE <= 3'b000;
      end else if (FlushE) begin
         RegWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         MemWriteE   <= 1'b0;
         ResultSrcE  <= 1'b0;
         BranchE     <= 1'b0;
         ALUControlE <= 3'b000;
      end else begin
         RegWriteE   <= reg_write;
         ALUSrcE     <= alu_src;
         MemWriteE   <= mem_write;
         ResultSrcE  <= result_src;
         BranchE     <= branch;
         ALUControlE <= alu_control;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RD1_E     <= 32'd0;
         RD2_E     <= 32'd0;
         Imm_Ext_E <= 32'd0;
         RD_E      <= 5'd0;
         RS1_E     <= 5'd0;
         RS2_E     <= 5'd0;
         PCE       <= 32'd0;
         PCPlus4E  <= 32'd0;
      end else if (clear_data) begin
         RD1_E     <= 32'd0;
         RD2_E     <= 32'd0;
         Imm_Ext_E <= 32'd0;
         RD_E      <= 5'd0;
         RS1_E     <= 5'd0;
         RS2_E     <= 5'd0;
         PCE       <= 32'd0;
         PCPlus4E  <= 32'd0;
      end else begin
         RD1_E     <= rd1;
         RD2_E     <= rd2;
         Imm_Ext_E <= imm_ext;
         RD_E      <= rd;
         RS1_E     <= rs1;
         RS2_E     <= rs2;
         PCE       <= PCD;
         PCPlus4E  <= PCPlus4D;
      end
   end

endmodule
